// File: rtl/uart_rx_oversampled_if.sv
// Receiver-side signal bundle for the oversampled UART receiver.
// The slave modport is the receiver; the master modport drives the line and
// acknowledges flags.
interface uart_rx_oversampled_if;
  logic       rx_serial_in;
  logic       rdy_clr;
  logic [7:0] rx_data_out;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;

  modport slave (
    input  rx_serial_in,
    input  rdy_clr,
    output rx_data_out,
    output rx_ready,
    output frame_err,
    output overrun
  );

  modport master (
    output rx_serial_in,
    output rdy_clr,
    input  rx_data_out,
    input  rx_ready,
    input  frame_err,
    input  overrun
  );
endinterface

// File: rtl/uart_rx_oversampled.sv
// 8N1 UART receiver, 16x oversampled. Detects the start bit on a tick,
// confirms it at mid-bit, then samples each data bit and the stop bit at
// their centres. Status flags are sticky until acknowledged with rdy_clr.
//
// state | meaning
// IDLE  | line idle, looking for a low sample on a tick
// START | start bit seen, counting to its centre to reject glitches
// DATA  | sampling 8 data bits, LSB first, once every 16 ticks
// STOP  | waiting for the centre of the stop bit
// BREAK | stop bit was low; wait for the line to return high
module uart_rx_oversampled #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic                   clk,
  input  logic                   reset,
  uart_rx_oversampled_if.slave   bus
);

  localparam int DIV   = CLK_FREQ / (BAUD * 16);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic             sync1_q, sync2_q;
  logic [DIV_W-1:0] div_q;
  logic [3:0]       samp_q, samp_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             ready_q, ready_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;
  logic             tick;
  logic             rx_s;
  logic             stop_ok;
  logic             stop_bad;

  assign rx_s = sync2_q;
  assign tick = (div_q == DIV_LAST);

  // Two-flop synchronizer; resets to the idle-high line level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= bus.rx_serial_in;
      sync2_q <= sync1_q;
    end
  end

  // Free-running oversample divider; tick is high for one clock at DIV-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q <= '0;
    end else if (tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  // State, counters, shift register and status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      samp_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      samp_q  <= samp_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  // Next-state, sampling and sticky-flag logic. A set in the same cycle as
  // rdy_clr wins, and an acknowledged completion is not an overrun.
  always_comb begin
    state_d  = state_q;
    samp_d   = samp_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    data_d   = data_q;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;

    case (state_q)
      IDLE: begin
        if (tick && !rx_s) begin
          state_d = START;
          samp_d  = '0;
        end
      end
      START: begin
        if (tick) begin
          if (samp_q == 4'd7) begin
            samp_d  = '0;
            bit_d   = '0;
            state_d = rx_s ? IDLE : DATA;
          end else begin
            samp_d = samp_q + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          samp_d = samp_q + 4'd1;
          if (samp_q == 4'd15) begin
            shift_d[bit_q] = rx_s;
            bit_d          = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              state_d = STOP;
            end
          end
        end
      end
      STOP: begin
        if (tick) begin
          samp_d = samp_q + 4'd1;
          if (samp_q == 4'd15) begin
            if (rx_s) begin
              stop_ok = 1'b1;
              data_d  = shift_q;
              state_d = IDLE;
            end else begin
              stop_bad = 1'b1;
              state_d  = BREAK;
            end
          end
        end
      end
      BREAK: begin
        if (tick && rx_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = bus.rdy_clr ? 1'b0 : ready_q;
    ferr_d  = bus.rdy_clr ? 1'b0 : ferr_q;
    ovr_d   = bus.rdy_clr ? 1'b0 : ovr_q;
    if (stop_ok) begin
      ready_d = 1'b1;
    end
    if (stop_bad) begin
      ferr_d = 1'b1;
    end
    if (stop_ok && ready_q && !bus.rdy_clr) begin
      ovr_d = 1'b1;
    end
  end

  assign bus.rx_data_out = data_q;
  assign bus.rx_ready    = ready_q;
  assign bus.frame_err   = ferr_q;
  assign bus.overrun     = ovr_q;

endmodule

// File: doc/uart_rx_oversampled.md
UART_RX_OVERSAMPLED -- requirements
Module: uart_rx_oversampled

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter CLK_FREQ, 50_000_000, system clock frequency in Hz.
REQ-003 Parameter BAUD, 115200, line rate in bit/s.
REQ-004 Derived constant DIV SHALL be CLK_FREQ/(BAUD*16), truncated; 27 at the defaults.
REQ-005 clk  input  1  system clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous active-high reset.
REQ-007 rx_serial_in  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-008 rdy_clr  input  1  one-cycle pulse; acknowledges and clears the status flags.
REQ-009 rx_data_out  output  8  last correctly framed byte.
REQ-010 rx_ready  output  1  sticky; a new byte is available.
REQ-011 frame_err  output  1  sticky; a stop bit was sampled low.
REQ-012 overrun  output  1  sticky; a byte completed while rx_ready was already 1.

Function
REQ-013 rx_serial_in SHALL pass through a 2-flop synchronizer, reset value 1; all logic uses the synchronized value (rx_s).
REQ-014 Tick generator: a free-running counter 0..DIV-1 SHALL emit a one-clock tick when the count equals DIV-1, then wrap to 0.
REQ-015 The FSM SHALL have states IDLE, START, DATA, STOP and BREAK; the reset state is IDLE.
REQ-016 IDLE: on a tick with rx_s=0, go to START and clear the 4-bit sample counter.
REQ-017 START: increment the sample counter per tick.
- On the tick where the count is 7 (mid start bit), go to DATA if rx_s=0; otherwise go to IDLE (glitch reject).
- Clear the sample counter and the bit index on leaving START.
REQ-018 DATA: increment the sample counter per tick; on every 16th tick (count wraps 15->0), shift rx_s into bit[bit_index] of the shift register.
- After bit_index 7 is sampled, go to STOP.
REQ-019 STOP: on the 16th tick, sample rx_s.
- If rx_s=1: load rx_data_out from the shift register, set rx_ready, go to IDLE.
- If rx_s=0: set frame_err, leave rx_data_out and rx_ready unchanged, go to BREAK.
REQ-020 BREAK: stay until a tick with rx_s=1, then go to IDLE; no start detection occurs in BREAK.
REQ-021 Latency: rx_ready, rx_data_out and frame_err SHALL update on the clock edge immediately after the stop-sample tick.
REQ-022 Overrun: on a successful stop while rx_ready=1 and rdy_clr=0, set overrun and overwrite rx_data_out with the new byte.
REQ-023 rdy_clr=1 SHALL clear rx_ready, frame_err and overrun on the next edge.
REQ-024 If a set condition and rdy_clr occur in the same cycle, the set SHALL win: the flag ends at 1 and overrun is not set.
REQ-025 rdy_clr SHALL have no effect on the FSM, counters or rx_data_out.
REQ-026 The end-to-end line-to-flag delay includes the 2-cycle synchronizer; the sample point SHALL stay within +/-1 tick of bit centre.

Reset
REQ-027 While reset=1, without waiting for clk:
- FSM SHALL be IDLE and all counters 0.
- Synchronizer flops SHALL be 1.
- rx_data_out=8'h00; rx_ready, frame_err and overrun SHALL be 0.
REQ-028 Reset asserted mid-frame SHALL abandon the frame; after release, the block SHALL wait for a fresh falling edge.

Verification (defaults, 20 ns clk, bit time = 16*27 = 432 clk)
REQ-029 Drive frame 0xA5 with a valid stop -> rx_data_out=8'hA5, rx_ready=1, frame_err=0, overrun=0 within 10 bit times of the start edge.
REQ-030 Pulse the line low for 100 clk, then hold high -> FSM returns to IDLE; rx_ready stays 0 and rx_data_out stays 8'h00.
REQ-031 Drive frame 0x3C with stop bit 0, then release the line high -> frame_err=1, rx_ready=0, rx_data_out unchanged; a following 0x81 frame is received correctly.
REQ-032 Drive frames 0x11 then 0x22 with no rdy_clr -> rx_data_out=8'h22, rx_ready=1, overrun=1; one rdy_clr pulse -> all three flags 0 and rx_data_out still 8'h22.
REQ-033 Assert reset for 3 clk during data bit 4 of a 0xFF frame -> outputs 0 immediately; a subsequent 0x5A frame is received with rx_ready=1.
REQ-034 Pulse rdy_clr on the exact cycle a 0x77 frame completes, with rx_ready previously 1 -> rx_ready=1, overrun=0, rx_data_out=8'h77.
